mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised M-stage load/store unit for the 5-stage MIPS pipeline. Decodes
//  lb/lbu/lh/lhu/lw/sb/sh/sw from the M-stage instruction, owns the word-organised
//  data RAM with byte enables, models MEM_LAT-cycle access latency with a stall
//  handshake, and flags misaligned/out-of-range accesses. Sits between the E/M and
//  M/W pipeline registers. Store data is forwarded from E or W.
// PARAMETERS
//  ADDR_W     10         word-address width; RAM holds 2**ADDR_W 32-bit words
//  MEM_LAT    1          access latency in cycles, legal range 1..4
//  BASE_ADDR  32'h0      byte address of RAM word 0
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  valid_in    in   1   M-stage slot holds a real instruction
//  instr       in   32  M-stage instruction word
//  pc_add_4    in   32  PC+4 of instr; used only for the store trace
//  mem_addr    in   32  byte address from ALU (E/M register)
//  wdata_e     in   32  store data from the E/M register
//  wdata_w     in   32  store data forwarded from W
//  fwd_sel     in   1   0: use wdata_e; 1: use wdata_w
//  stall       out  1   hold PC, F/D, D/E and E/M; insert bubble into M/W
//  load_data   out  32  sign/zero-extended load result; valid when stall=0
//  alu_result  out  32  mem_addr passed through unchanged
//  addr_exc    out  1   completing access is misaligned or out of range
//  mem_we      out  1   RAM write strobe for this edge
//  byte_en     out  4   byte lanes written; bit i = byte [8i+7:8i]
// BEHAVIOUR
//  - Opcodes: lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000,
//    sh 101001, sw 101011. Any other opcode, or valid_in=0, is a non-memory op:
//    stall=0, mem_we=0, byte_en=0, addr_exc=0, load_data=0.
//  - Store data: 0 when instr[20:16]==0, else wdata_e or wdata_w per fwd_sel.
//    It is replicated into the lanes: sb uses byte x4, sh uses half x2.
//  - Word index = (mem_addr-BASE_ADDR)>>2. Out of range when the offset is
//    >= 4*2**ADDR_W or mem_addr < BASE_ADDR.
//  - Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
//  - On exception: no RAM write, load_data=0, addr_exc=1 in the completing cycle only.
//  - byte_en: sb gives 4'b0001<<addr[1:0]; sh gives 4'b0011<<addr[1:0]; sw gives 4'hF;
//    loads give 0.
//  - FSM states IDLE and WAIT; 3-bit down-counter cnt.
//    IDLE, mem op with MEM_LAT=1: completes this cycle, stall=0, stay IDLE.
//    IDLE, mem op with MEM_LAT>1: stall=1; at the edge go to WAIT with cnt=MEM_LAT-1.
//    WAIT: stall=(cnt!=1); cnt decrements each edge. With cnt==1 this is the
//    completing cycle (stall=0) and the next edge returns to IDLE.
//  - Each access therefore occupies MEM_LAT cycles, with stall high for MEM_LAT-1.
//  - Commit: in the completing cycle only, mem_we = store & ~exc. The RAM write
//    happens at that edge. Loads read combinationally in the completing cycle,
//    extending by opcode.
//  - Upstream holds all inputs stable while stall=1. If valid_in falls in WAIT,
//    the access aborts: go to IDLE, no write, stall=0 in that same cycle.
//  - Reset low, asynchronous: go to IDLE with cnt=0. stall, mem_we, byte_en and
//    addr_exc drop at once. All RAM words clear to 0. A store in flight is
//    discarded and never written.
//  - Each committed store prints $display("%d@%h: *%h <= %h", $time, pc_add_4-4,
//    word-aligned addr, merged word).
// TESTING
//  1 MEM_LAT=1: sw 0x12345678 @0x10, then lw @0x10 -> load_data=0x12345678, stall never high.
//  2 sb 0x80 @0x13 over 0 -> word 0x80000000, byte_en=4'b1000; lb @0x13 gives
//    0xFFFFFF80; lbu gives 0x00000080; lhu @0x12 gives 0x00008000.
//  3 MEM_LAT=3: sw -> stall=1 for 2 cycles, mem_we=1 only in cycle 3; a
//    back-to-back lw completes 3 cycles later.
//  4 lw @0x6 and sh @0x5 -> addr_exc=1 and mem_we=0; memory unchanged.
//    Addr 4*2**ADDR_W -> addr_exc=1.
//  5 MEM_LAT=4: reset low in the 2nd stall cycle of sw -> stall=0 immediately,
//    state IDLE; later lw of that address gives 0.
//  6 sw with rt=0 -> stores 0. fwd_sel=1 stores wdata_w; fwd_sel=0 stores wdata_e.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage load/store unit with latency-modelled, byte-enabled data RAM
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   valid_in, instr     M-stage slot valid and instruction word
//   pc_add_4            PC+4 of instr, used for the store trace only
//   mem_addr            byte address from the E/M register
//   wdata_e, wdata_w    store data from E/M or forwarded from W, chosen by fwd_sel
//   stall               holds upstream stages while an access is in progress
//   load_data           extended load result, valid in the completing cycle
//   alu_result          mem_addr passed through
//   addr_exc            completing access is misaligned or out of range
//   mem_we, byte_en     RAM write strobe and written byte lanes
module mem_stage_lsu #(
  parameter int          ADDR_W    = 10,
  parameter int          MEM_LAT   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] instr,
  input  logic [31:0] pc_add_4,
  input  logic [31:0] mem_addr,
  input  logic [31:0] wdata_e,
  input  logic [31:0] wdata_w,
  input  logic        fwd_sel,
  output logic        stall,
  output logic [31:0] load_data,
  output logic [31:0] alu_result,
  output logic        addr_exc,
  output logic        mem_we,
  output logic [3:0]  byte_en
);

  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [32:0] SPAN   = 33'd4 << ADDR_W;
  localparam logic [2:0]  LAT_M1 = 3'(MEM_LAT - 1);

  logic [5:0]        opcode;
  logic              is_load;
  logic              is_store;
  logic              is_byte;
  logic              is_half;
  logic              is_word;
  logic              is_unsigned;
  logic              mem_op;
  logic [31:0]       offset;
  logic              out_range;
  logic              misaligned;
  logic              exc;
  logic [ADDR_W-1:0] word_idx;
  logic [0:0]        state;
  logic [2:0]        cnt;
  logic              complete;
  logic              commit_we;
  logic [3:0]        lanes;
  logic [31:0]       src;
  logic [31:0]       wlane;
  logic [31:0]       rd_word;
  logic [31:0]       merged;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [31:0]       ram [DEPTH];
  logic              unused_bits;

  assign opcode = instr[31:26];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (opcode)
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: is_load  = 1'b1;
      6'b101000, 6'b101001, 6'b101011:                        is_store = 1'b1;
      default: ;
    endcase
  end

  // Access size and signedness are encoded directly in the low opcode bits.
  assign is_byte     = (opcode[1:0] == 2'b00);
  assign is_half     = (opcode[1:0] == 2'b01);
  assign is_word     = (opcode[1:0] == 2'b11);
  assign is_unsigned = opcode[2];
  assign mem_op      = valid_in & (is_load | is_store);

  assign offset     = mem_addr - BASE_ADDR;
  assign out_range  = (mem_addr < BASE_ADDR) | ({1'b0, offset} >= SPAN);
  assign misaligned = (is_half & mem_addr[0]) | (is_word & (mem_addr[1:0] != 2'b00));
  assign exc        = out_range | misaligned;
  assign word_idx   = offset[ADDR_W+1:2];

  // Outputs are gated by reset so they drop immediately when reset asserts.
  assign complete  = reset & mem_op &
                     (((state == S_IDLE) && (MEM_LAT == 1)) ||
                      ((state == S_WAIT) && (cnt == 3'd1)));
  assign stall     = reset & mem_op & ~complete;
  assign commit_we = complete & is_store & ~exc;
  assign mem_we    = commit_we;
  assign addr_exc  = complete & exc;
  assign alu_result = mem_addr;

  always_comb begin
    lanes = 4'hF;
    if (is_byte)      lanes = 4'b0001 << mem_addr[1:0];
    else if (is_half) lanes = 4'b0011 << mem_addr[1:0];
  end

  assign byte_en = (reset & mem_op & is_store) ? lanes : 4'h0;

  assign src = (instr[20:16] == 5'd0) ? 32'h0 : (fwd_sel ? wdata_w : wdata_e);

  always_comb begin
    wlane = src;
    if (is_byte)      wlane = {4{src[7:0]}};
    else if (is_half) wlane = {2{src[15:0]}};
  end

  assign rd_word = ram[word_idx];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = wlane[8*i +: 8];
    end
  end

  assign rbyte = rd_word[{mem_addr[1:0], 3'b000} +: 8];
  assign rhalf = rd_word[{mem_addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'h0;
    if (complete & is_load & ~exc) begin
      if (is_byte)      load_data = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      else if (is_half) load_data = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      else              load_data = rd_word;
    end
  end

  // A dropped valid_in in WAIT aborts the access and returns to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_op && (MEM_LAT > 1)) begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        default: begin
          if (!mem_op) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else if (cnt == 3'd1) begin
            state <= S_IDLE;
            cnt   <= cnt - 3'd1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h0;
    end else if (commit_we) begin
      ram[word_idx] <= merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && commit_we)
      $display("%d@%h: *%h <= %h", $time, pc_add_4 - 32'd4, {mem_addr[31:2], 2'b00}, merged);
  end
`endif

  assign unused_bits = ^{instr[25:21], instr[15:0], pc_add_4};

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu at MEM_LAT 1, 3 and 4
module tb_mem_stage_lsu;

  localparam int AW = 6;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_ADD = 6'b000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_in [3];
  logic [31:0] instr [3];
  logic [31:0] pc_add_4 [3];
  logic [31:0] mem_addr [3];
  logic [31:0] wdata_e [3];
  logic [31:0] wdata_w [3];
  logic        fwd_sel [3];
  logic        stall [3];
  logic [31:0] load_data [3];
  logic [31:0] alu_result [3];
  logic        addr_exc [3];
  logic        mem_we [3];
  logic [3:0]  byte_en [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_lsu #(
      .ADDR_W(AW),
      .MEM_LAT((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .BASE_ADDR(32'h0)
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .valid_in(valid_in[g]),
      .instr(instr[g]),
      .pc_add_4(pc_add_4[g]),
      .mem_addr(mem_addr[g]),
      .wdata_e(wdata_e[g]),
      .wdata_w(wdata_w[g]),
      .fwd_sel(fwd_sel[g]),
      .stall(stall[g]),
      .load_data(load_data[g]),
      .alu_result(alu_result[g]),
      .addr_exc(addr_exc[g]),
      .mem_we(mem_we[g]),
      .byte_en(byte_en[g])
    );
  end

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        exc;
    logic        we;
    logic [3:0]  be;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  task automatic drive(input int k, input logic [5:0] op, input logic [31:0] addr,
                       input logic [4:0] rt, input logic fwd,
                       input logic [31:0] de, input logic [31:0] dw);
    valid_in[k] = 1'b1;
    instr[k]    = {op, 5'd1, rt, 16'h0};
    pc_add_4[k] = 32'h0040_0004 + {addr[29:0], 2'b00};
    mem_addr[k] = addr;
    wdata_e[k]  = de;
    wdata_w[k]  = dw;
    fwd_sel[k]  = fwd;
  endtask

  // Entered and left at 1 time unit after a rising edge; consecutive calls are back-to-back.
  task automatic run_op(input int k, input string name, input logic [5:0] op,
                        input logic [31:0] addr, input logic [4:0] rt, input logic fwd,
                        input logic [31:0] de, input logic [31:0] dw,
                        input logic [31:0] exp_ld, input logic exp_exc, input logic [3:0] exp_be);
    exp_t e;
    int   stalls;
    bit   done;
    e.name   = name;
    e.ld     = exp_ld;
    e.exc    = exp_exc;
    e.we     = (op[5:3] == 3'b101) && !exp_exc;
    e.be     = exp_be;
    e.stalls = op[5] ? lat_of(k) - 1 : 0;
    sb_q.push_back(e);
    drive(k, op, addr, rt, fwd, de, dw);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      @(negedge clk);
      if (stall[k]) begin
        stalls++;
        checks++;
        if (mem_we[k] !== 1'b0 || addr_exc[k] !== 1'b0) begin
          errors++;
          $display("FAIL %s early_commit we=%b exc=%b required 0 0", name, mem_we[k], addr_exc[k]);
        end
        @(posedge clk);
        #1;
      end else begin
        done = 1'b1;
      end
    end
    e = sb_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout stall still high required completion", e.name);
    end else begin
      if (stalls !== e.stalls) begin
        errors++;
        $display("FAIL %s stall_cycles got %0d required %0d", e.name, stalls, e.stalls);
      end
      checks++;
      if (load_data[k] !== e.ld) begin
        errors++;
        $display("FAIL %s load_data got %h required %h", e.name, load_data[k], e.ld);
      end
      checks++;
      if (addr_exc[k] !== e.exc) begin
        errors++;
        $display("FAIL %s addr_exc got %b required %b", e.name, addr_exc[k], e.exc);
      end
      checks++;
      if (mem_we[k] !== e.we) begin
        errors++;
        $display("FAIL %s mem_we got %b required %b", e.name, mem_we[k], e.we);
      end
      if (!e.exc) begin
        checks++;
        if (byte_en[k] !== e.be) begin
          errors++;
          $display("FAIL %s byte_en got %b required %b", e.name, byte_en[k], e.be);
        end
      end
      checks++;
      if (alu_result[k] !== addr) begin
        errors++;
        $display("FAIL %s alu_result got %h required %h", e.name, alu_result[k], addr);
      end
    end
    @(posedge clk);
    #1;
    valid_in[k] = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) drive(k, OP_SW, 32'h20, 5'd3, 1'b0, 32'h1, 32'h2);
    #3;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall[k] !== 1'b0 || mem_we[k] !== 1'b0 || addr_exc[k] !== 1'b0 || byte_en[k] !== 4'h0) begin
        errors++;
        $display("FAIL reset_outputs lane%0d stall=%b we=%b exc=%b be=%b required 0 0 0 0",
                 k, stall[k], mem_we[k], addr_exc[k], byte_en[k]);
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) valid_in[k] = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_byte_half;
    run_op(0, "sb_13", OP_SB, 32'h13, 5'd5, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 4'b1000);
    run_op(0, "lw_10_after_sb", OP_LW, 32'h10, 5'd0, 1'b0, 0, 0, 32'h8000_0000, 1'b0, 4'h0);
    run_op(0, "lb_13", OP_LB, 32'h13, 5'd0, 1'b0, 0, 0, 32'hFFFF_FF80, 1'b0, 4'h0);
    run_op(0, "lbu_13", OP_LBU, 32'h13, 5'd0, 1'b0, 0, 0, 32'h0000_0080, 1'b0, 4'h0);
    run_op(0, "lhu_12", OP_LHU, 32'h12, 5'd0, 1'b0, 0, 0, 32'h0000_8000, 1'b0, 4'h0);
    run_op(0, "lh_12", OP_LH, 32'h12, 5'd0, 1'b0, 0, 0, 32'hFFFF_8000, 1'b0, 4'h0);
    run_op(0, "lb_12", OP_LB, 32'h12, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic test_lat1_basic;
    run_op(0, "sw_10", OP_SW, 32'h10, 5'd5, 1'b0, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 4'hF);
    run_op(0, "lw_10", OP_LW, 32'h10, 5'd0, 1'b0, 0, 0, 32'h1234_5678, 1'b0, 4'h0);
    run_op(0, "lb_11", OP_LB, 32'h11, 5'd0, 1'b0, 0, 0, 32'h0000_0056, 1'b0, 4'h0);
    run_op(0, "lh_10", OP_LH, 32'h10, 5'd0, 1'b0, 0, 0, 32'h0000_5678, 1'b0, 4'h0);
    run_op(0, "lhu_12", OP_LHU, 32'h12, 5'd0, 1'b0, 0, 0, 32'h0000_1234, 1'b0, 4'h0);
  endtask

  task automatic test_exceptions;
    run_op(0, "sw_04", OP_SW, 32'h4, 5'd2, 1'b0, 32'hAAAA_AAAA, 0, 32'h0, 1'b0, 4'hF);
    run_op(0, "lw_06_misalign", OP_LW, 32'h6, 5'd0, 1'b0, 0, 0, 32'h0, 1'b1, 4'h0);
    run_op(0, "sh_05_misalign", OP_SH, 32'h5, 5'd2, 1'b0, 32'hBBBB, 0, 32'h0, 1'b1, 4'h0);
    run_op(0, "lw_04_unchanged", OP_LW, 32'h4, 5'd0, 1'b0, 0, 0, 32'hAAAA_AAAA, 1'b0, 4'h0);
    run_op(0, "sh_06", OP_SH, 32'h6, 5'd2, 1'b0, 32'hBBBB, 0, 32'h0, 1'b0, 4'b1100);
    run_op(0, "lw_04_after_sh", OP_LW, 32'h4, 5'd0, 1'b0, 0, 0, 32'hBBBB_AAAA, 1'b0, 4'h0);
    run_op(0, "sw_100_range", OP_SW, 32'h100, 5'd2, 1'b0, 32'h1, 0, 32'h0, 1'b1, 4'h0);
    run_op(0, "lw_100_range", OP_LW, 32'h100, 5'd0, 1'b0, 0, 0, 32'h0, 1'b1, 4'h0);
    run_op(0, "lb_101_range", OP_LB, 32'h101, 5'd0, 1'b0, 0, 0, 32'h0, 1'b1, 4'h0);
    run_op(0, "lw_fc_last", OP_LW, 32'hFC, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
    run_op(0, "lw_00_untouched", OP_LW, 32'h0, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic test_fwd;
    run_op(0, "sw_20_pre", OP_SW, 32'h20, 5'd4, 1'b0, 32'h5A5A_5A5A, 32'h0, 32'h0, 1'b0, 4'hF);
    run_op(0, "sw_20_rt0", OP_SW, 32'h20, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'hF);
    run_op(0, "lw_20_rt0", OP_LW, 32'h20, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
    run_op(0, "sw_24_fwd_w", OP_SW, 32'h24, 5'd7, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 4'hF);
    run_op(0, "lw_24_fwd_w", OP_LW, 32'h24, 5'd0, 1'b0, 0, 0, 32'h2222_2222, 1'b0, 4'h0);
    run_op(0, "sw_28_fwd_e", OP_SW, 32'h28, 5'd7, 1'b0, 32'h1111_1111, 32'h2222_2222, 32'h0, 1'b0, 4'hF);
    run_op(0, "lw_28_fwd_e", OP_LW, 32'h28, 5'd0, 1'b0, 0, 0, 32'h1111_1111, 1'b0, 4'h0);
  endtask

  task automatic test_nonmem;
    run_op(0, "add_lane0", OP_ADD, 32'h30, 5'd5, 1'b0, 32'h9, 32'h9, 32'h0, 1'b0, 4'h0);
    run_op(2, "add_lane2", OP_ADD, 32'h6, 5'd5, 1'b0, 32'h9, 32'h9, 32'h0, 1'b0, 4'h0);
    drive(2, OP_LW, 32'h10, 5'd0, 1'b0, 0, 0);
    valid_in[2] = 1'b0;
    #2;
    checks++;
    if (stall[2] !== 1'b0 || load_data[2] !== 32'h0 || mem_we[2] !== 1'b0) begin
      errors++;
      $display("FAIL invalid_slot stall=%b load_data=%h we=%b required 0 0 0",
               stall[2], load_data[2], mem_we[2]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    run_op(1, "lat3_sw_40", OP_SW, 32'h40, 5'd6, 1'b0, 32'hCAFE_F00D, 0, 32'h0, 1'b0, 4'hF);
    run_op(1, "lat3_lw_40", OP_LW, 32'h40, 5'd0, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0, 4'h0);
    run_op(1, "lat3_sb_41", OP_SB, 32'h41, 5'd6, 1'b0, 32'h0000_00EE, 0, 32'h0, 1'b0, 4'b0010);
    run_op(1, "lat3_lw_40b", OP_LW, 32'h40, 5'd0, 1'b0, 0, 0, 32'hCAFE_EE0D, 1'b0, 4'h0);
    run_op(1, "lat3_lw_06_exc", OP_LW, 32'h6, 5'd0, 1'b0, 0, 0, 32'h0, 1'b1, 4'h0);
  endtask

  task automatic test_abort;
    drive(1, OP_SW, 32'h48, 5'd3, 1'b0, 32'h5555_5555, 0);
    @(negedge clk);
    checks++;
    if (stall[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_first_stall got %b required 1", stall[1]);
    end
    @(posedge clk);
    #1;
    valid_in[1] = 1'b0;
    #1;
    checks++;
    if (stall[1] !== 1'b0 || mem_we[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_release stall=%b we=%b required 0 0", stall[1], mem_we[1]);
    end
    @(posedge clk);
    #1;
    run_op(1, "abort_lw_48", OP_LW, 32'h48, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic test_reset_abort;
    run_op(2, "lat4_sw_20", OP_SW, 32'h20, 5'd5, 1'b0, 32'h1111_1111, 0, 32'h0, 1'b0, 4'hF);
    run_op(2, "lat4_lw_20", OP_LW, 32'h20, 5'd0, 1'b0, 0, 0, 32'h1111_1111, 1'b0, 4'h0);
    drive(2, OP_SW, 32'h20, 5'd5, 1'b0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (stall[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_second_stall got %b required 1", stall[2]);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (stall[2] !== 1'b0 || mem_we[2] !== 1'b0 || byte_en[2] !== 4'h0 || addr_exc[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_drop stall=%b we=%b be=%b exc=%b required 0 0 0 0",
               stall[2], mem_we[2], byte_en[2], addr_exc[2]);
    end
    @(posedge clk);
    #1;
    valid_in[2] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_op(2, "lat4_lw_20_after_rst", OP_LW, 32'h20, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
    run_op(0, "lat1_lw_10_after_rst", OP_LW, 32'h10, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      valid_in[k] = 1'b0;
      instr[k]    = 32'h0;
      pc_add_4[k] = 32'h0;
      mem_addr[k] = 32'h0;
      wdata_e[k]  = 32'h0;
      wdata_w[k]  = 32'h0;
      fwd_sel[k]  = 1'b0;
    end
    test_reset;
    test_byte_half;
    test_lat1_basic;
    test_exceptions;
    test_fwd;
    test_nonmem;
    test_latency;
    test_abort;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
